mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

- Core-side initiator for the data-memory valid/yumi handshake.
- Takes one load/store request at a time from the execute stage and drives it onto the data-memory request port.
- Waits for acceptance and response, releases the memory with yumi, and returns one registered completion (data or error) to the core.
- Sits between the core pipeline and the data memory; the core stalls while `req_ready_o` is low.

## Interface
- `TIMEOUT_P`, default 255: cycles allowed in REQ+WAIT before abort (only with `MEM_REQ_TIMEOUT_EN`).
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid_i` in 1: core request; sampled only when `req_ready_o`=1.
- `req_wen_i` in 1: 1 = store, 0 = load.
- `req_byte_i` in 1: 1 = byte access, 0 = word access.
- `req_signed_i` in 1: sign-extend byte loads.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data; byte stores use [7:0].
- `req_ready_o` out 1: high only in IDLE.
- `resp_valid_o` out 1: one-cycle completion pulse.
- `resp_data_o` out 32: load data; 0 for stores and errors.
- `resp_err_o` out 1: qualified by `resp_valid_o`.
- `mem_valid_o` out 1: request valid to memory.
- `mem_wen_o` out 1: request write enable.
- `mem_byte_not_word_o` out 1: request size.
- `mem_addr_o` out 32: request address.
- `mem_wdata_o` out 32: request write data.
- `mem_yumi_o` out 1: response consumed.
- `mem_yumi_i` in 1: memory accepted request.
- `mem_valid_i` in 1: memory response valid.
- `mem_rdata_i` in 32: memory read data; byte reads arrive zero-extended in [7:0].

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - `req_ready_o`=1.
  - On `req_valid_i`, latch wen/byte/signed/addr/wdata.
  - Misalignment check: word access with `addr[1:0]`≠0 → DONE with err=1, never issued to memory.
  - Otherwise → REQ.
- REQ
  - `mem_valid_o`=1; all `mem_*` request outputs come from the latched registers and are stable while in REQ.
  - On `mem_yumi_i`, → WAIT.
  - If `mem_yumi_i` and `mem_valid_i` are both high, go straight to completion, as in WAIT.
- WAIT
  - `mem_valid_o`=0.
  - On `mem_valid_i`, `mem_yumi_o`=1 combinationally in that same cycle.
  - Capture data → DONE.
  - Load byte: `resp_data` = {24'b0, rdata[7:0]}, or sign-extended from bit 7 if signed.
  - Load word: `resp_data` = rdata.
  - Store: `resp_data` = 0.
- DONE
  - `resp_valid_o`=1 for exactly one cycle → IDLE.
- `mem_yumi_o` is combinational: (WAIT|REQ)&`mem_valid_i`, or IDLE&`mem_valid_i` (drain).
- Drain: any `mem_valid_i` seen in IDLE is a stale response (after reset or abort). Acknowledge it with `mem_yumi_o` and discard it; `resp_valid_o` stays 0.
- Reset mid-operation: all state is dropped and the FSM → IDLE. No response is reported for the lost request; a late memory response is drained.

## Timing
- Reset values: state IDLE, `req_ready_o`=1, `resp_valid_o`=0, `resp_data_o`=0, `resp_err_o`=0, `mem_valid_o`=0, `mem_yumi_o`=0 (absent `mem_valid_i`), other `mem_*` outputs 0.
- Zero-latency memory (yumi same cycle as valid, response valid next cycle):
  - Cycle 0: request accepted in IDLE.
  - Cycle 1: REQ, memory yumi.
  - Cycle 2: WAIT, memory valid, `mem_yumi_o`.
  - Cycle 3: `resp_valid_o`.
- Throughput is one request per 4 cycles; the next request is accepted in cycle 4.
- Misaligned request: `resp_valid_o`+err in cycle 1.
- Memory stall in REQ or WAIT: the FSM holds indefinitely unless timeout is enabled.

## Configuration
- `MEM_REQ_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to REQ and increments every REQ/WAIT cycle.
  - When it reaches `TIMEOUT_P`: → DONE with err=1, data=0, and `mem_valid_o` drops.
  - The late response is later drained in IDLE.
- Undefined:
  - No counter logic is present.
  - `resp_err_o` is set only for misalignment.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → load `resp_valid_o` in cycle 3 after acceptance, data 0xDEADBEEF, err 0.
- Byte store 0x80 to 0x21, then byte load from 0x21 with signed=1 → data 0xFFFFFF80; repeat with signed=0 → 0x00000080.
- Word load from 0x22 → `resp_valid_o` with err=1 in cycle 1, `mem_valid_o` never asserted.
- Memory model delays yumi 5 cycles and valid 3 more → `mem_*` outputs stable throughout REQ, `mem_yumi_o` high exactly in the `mem_valid_i` cycle, one `resp_valid_o`.
- Reset asserted in WAIT, memory valid arrives after reset → `mem_yumi_o` drains it, no `resp_valid_o`, next load completes normally.
- With `MEM_REQ_TIMEOUT_EN` and `TIMEOUT_P`=8, memory never yumis → err=1 response 8 cycles after entering REQ; without the macro, `req_ready_o` stays 0 for 100 cycles.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: core-side initiator for the data-memory valid/yumi handshake.
// Optional REQ/WAIT abort timer is enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl #(
  parameter int TIMEOUT_P = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic        req_byte_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        mem_valid_o,
  output logic        mem_wen_o,
  output logic        mem_byte_not_word_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_yumi_o,
  input  logic        mem_yumi_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic        byte_q, byte_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] load_data;
  logic        tmo;

  // Byte reads arrive zero-extended; only bit 7 decides the sign.
  always_comb begin
    if (byte_q) begin
      load_data = {{24{signed_q & mem_rdata_i[7]}},
                   mem_rdata_i[7:0]};
    end else begin
      load_data = mem_rdata_i;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW_L = ($clog2(TIMEOUT_P + 1) > 8)
                      ? $clog2(TIMEOUT_P + 1) : 8;
  logic [CW_L-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == CW_L'(TIMEOUT_P - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_p;

  assign tmo = 1'b0;
  assign unused_timeout_p = (TIMEOUT_P != 0);
`endif

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    byte_d     = byte_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_yumi_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Anything arriving here is stale and is simply drained.
        mem_yumi_o = mem_valid_i;
        if (req_valid_i) begin
          wen_d    = req_wen_i;
          byte_d   = req_byte_i;
          signed_d = req_signed_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          if (!req_byte_i && req_addr_i[1:0] != 2'b00) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_yumi_o = mem_valid_i;
        if (mem_yumi_i && mem_valid_i) begin
          state_d = DONE;
          rdata_d = wen_q ? '0 : load_data;
          err_d   = 1'b0;
        end else if (mem_yumi_i) begin
          state_d = WAIT;
        end else if (tmo) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      WAIT: begin
        mem_yumi_o = mem_valid_i;
        if (mem_valid_i) begin
          state_d = DONE;
          rdata_d = wen_q ? '0 : load_data;
          err_d   = 1'b0;
        end else if (tmo) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wen_q    <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o         = (state_q == IDLE);
  assign resp_valid_o        = (state_q == DONE);
  assign resp_data_o         = rdata_q;
  assign resp_err_o          = err_q;
  assign mem_valid_o         = (state_q == REQ);
  assign mem_wen_o           = wen_q;
  assign mem_byte_not_word_o = byte_q;
  assign mem_addr_o          = addr_q;
  assign mem_wdata_o         = wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed and random load/store traffic against
// a behavioural memory, with a scoreboard of expected completions.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_wen_i, req_byte_i, req_signed_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic [31:0] resp_data_o;
  logic        mem_valid_o, mem_wen_o, mem_byte_not_word_o, mem_yumi_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_yumi_i, mem_valid_i;
  logic [31:0] mem_rdata_i;

  mem_req_ctrl #(.TIMEOUT_P(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid_i         (req_valid_i),
    .req_wen_i           (req_wen_i),
    .req_byte_i          (req_byte_i),
    .req_signed_i        (req_signed_i),
    .req_addr_i          (req_addr_i),
    .req_wdata_i         (req_wdata_i),
    .req_ready_o         (req_ready_o),
    .resp_valid_o        (resp_valid_o),
    .resp_data_o         (resp_data_o),
    .resp_err_o          (resp_err_o),
    .mem_valid_o         (mem_valid_o),
    .mem_wen_o           (mem_wen_o),
    .mem_byte_not_word_o (mem_byte_not_word_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_yumi_o          (mem_yumi_o),
    .mem_yumi_i          (mem_yumi_i),
    .mem_valid_i         (mem_valid_i),
    .mem_rdata_i         (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  logic [7:0] dev_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  // memory model controls, set by stimulus
  int          phase = 0;
  int          cnt = 0;
  bit          hang = 0;
  bit          exp_issue = 0;
  bit          taken = 0;
  logic [31:0] rd;
  logic        cur_wen, cur_byte;
  logic [31:0] cur_addr, cur_wdata;
  int          cur_yd, cur_vd;
  int          issue_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Behavioural memory: yumi after cur_yd idle REQ cycles, response
  // cur_vd cycles later (cur_vd < 0: response together with yumi).
  initial begin
    mem_yumi_i  = 1'b0;
    mem_valid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_yumi_i = 1'b0;
      if (phase == 3 && taken) begin
        mem_valid_i = 1'b0;
        mem_rdata_i = '0;
        phase = 0;
      end
      if (phase == 2 || phase == 3)
        chk("mem_valid_in_wait", mem_valid_o, 0);
      if (phase == 2) begin
        if (cnt == 0) begin
          mem_valid_i = 1'b1;
          mem_rdata_i = rd;
          phase = 3;
        end else begin
          cnt--;
        end
      end
      if (phase == 0 && mem_valid_o && !hang) begin
        chk("mem_valid_expected", exp_issue, 1);
        exp_issue = 0;
        cnt = cur_yd;
        phase = 1;
      end
      if (phase == 1) begin
        chk("req_valid_hold", mem_valid_o, 1);
        chk("req_wen", mem_wen_o, cur_wen);
        chk("req_byte", mem_byte_not_word_o, cur_byte);
        chk("req_addr", mem_addr_o, cur_addr);
        chk("req_wdata", mem_wdata_o, cur_wdata);
        if (cnt == 0) begin
          mem_yumi_i = 1'b1;
          if (mem_wen_o) begin
            if (mem_byte_not_word_o) begin
              dev_mem[mem_addr_o] = mem_wdata_o[7:0];
            end else begin
              for (int i = 0; i < 4; i++)
                dev_mem[mem_addr_o + 32'(i)] = mem_wdata_o[8*i +: 8];
            end
            rd = $urandom;
          end else if (mem_byte_not_word_o) begin
            rd = {24'h0, dev_rd(mem_addr_o)};
          end else begin
            rd = {dev_rd(mem_addr_o + 32'd3), dev_rd(mem_addr_o + 32'd2),
                  dev_rd(mem_addr_o + 32'd1), dev_rd(mem_addr_o)};
          end
          if (cur_vd < 0) begin
            mem_valid_i = 1'b1;
            mem_rdata_i = rd;
            phase = 3;
          end else begin
            cnt = cur_vd;
            phase = 2;
          end
        end else begin
          cnt--;
        end
      end
      #1;
      taken = mem_valid_i && mem_yumi_o;
      chk("mem_yumi_o", mem_yumi_o, mem_valid_i);
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid_o) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL resp_unexpected: got data %h err %b expected none",
                   resp_data_o, resp_err_o);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_data"}, resp_data_o, e.data);
          chk({e.nm, "_err"}, resp_err_o, e.err);
          chk({e.nm, "_cycle"}, cyc, e.due);
        end
      end
    end
  end

  task automatic issue_raw(input logic wen, input logic byt,
                           input logic sgn, input logic [31:0] addr,
                           input logic [31:0] wdata, input int yd,
                           input int vd, input bit push, input exp_t e);
    @(negedge clk);
    chk("req_ready", req_ready_o, 1);
    cur_wen   = wen;
    cur_byte  = byt;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_yd    = yd;
    cur_vd    = vd;
    exp_issue = byt || addr[1:0] == 2'b00;
    issue_cyc = cyc;
    if (push) sb.push_back(e);
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_byte_i   = byt;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(negedge clk);
    req_valid_i  = 1'b0;
    req_wen_i    = $urandom_range(0, 1);
    req_byte_i   = $urandom_range(0, 1);
    req_signed_i = $urandom_range(0, 1);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(sb.size() == 0 && phase == 0 && !mem_valid_i)
               && n < maxc);
    if (n >= maxc) begin
      nchk++;
      nerr++;
      $display("FAIL wait_done: still busy after %0d cycles, required idle",
               maxc);
      sb.delete();
    end
  endtask

  task automatic issue(input logic wen, input logic byt, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int yd, input int vd, input string nm);
    exp_t       e;
    logic [7:0] b;
    int         lat;
    e.nm = nm;
    if (!byt && addr[1:0] != 2'b00) begin
      e.data = 0;
      e.err  = 1;
      lat    = 1;
    end else begin
      e.err = 0;
      lat   = (vd < 0) ? 2 + yd : 3 + yd + vd;
      if (wen) begin
        e.data = 0;
        if (byt) ref_mem[addr] = wdata[7:0];
        else for (int i = 0; i < 4; i++)
          ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end else if (byt) begin
        b = ref_rd(addr);
        e.data = (sgn && b >= 8'd128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
      end else begin
        e.data = 0;
        for (int i = 0; i < 4; i++)
          e.data = e.data + (32'(ref_rd(addr + 32'(i))) << (8 * i));
      end
    end
    // due is relative to the negedge on which the request is driven
    e.due = cyc + 1 + lat;
    issue_raw(wen, byt, sgn, addr, wdata, yd, vd, 1'b1, e);
    wait_done(300);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   n;
    bit   ready_seen;
    exp_t e;
    reset        = 1'b1;
    req_valid_i  = 1'b0;
    req_wen_i    = 1'b0;
    req_byte_i   = 1'b0;
    req_signed_i = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_wen", mem_wen_o, 0);
    chk("rst_mem_byte", mem_byte_not_word_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_mem_yumi", mem_yumi_o, 0);

    issue(1, 0, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, "st_word");
    t0 = issue_cyc;
    issue(0, 0, 0, 32'h10, 32'h0, 0, 0, "ld_word");
    chk("throughput", issue_cyc - t0, 4);

    issue(1, 1, 0, 32'h21, 32'h1234_5680, 0, 0, "st_byte");
    issue(0, 1, 1, 32'h21, 32'h0, 0, 0, "ld_byte_s");
    issue(0, 1, 0, 32'h21, 32'h0, 0, 0, "ld_byte_u");
    issue(0, 0, 0, 32'h22, 32'h0, 0, 0, "misalign");
    issue(0, 0, 0, 32'h10, 32'h0, 5, 3, "slow_mem");
    issue(0, 0, 0, 32'h10, 32'h0, 0, -1, "fast_mem");

    // reset while waiting for the response; the late response is drained
    e.nm = "none";
    issue_raw(0, 0, 0, 32'h10, 32'h0, 0, 6, 1'b0, e);
    n = 0;
    while (phase != 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_wait", phase, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_done(50);
    chk("after_drain_ready", req_ready_o, 1);
    issue(0, 0, 0, 32'h10, 32'h0, 0, 0, "ld_after_rst");

    for (int k = 0; k < 60; k++) begin
      logic        wen, byt, sgn;
      logic [31:0] addr;
      wen  = $urandom_range(0, 1);
      byt  = $urandom_range(0, 1);
      sgn  = $urandom_range(0, 1);
      addr = 32'h100 + $urandom_range(0, 31);
      if (!byt && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      issue(wen, byt, sgn, addr, $urandom, $urandom_range(0, 3),
            int'($urandom_range(0, 4)) - 1, "rand");
    end

    // memory never accepts
    hang = 1;
`ifdef MEM_REQ_TIMEOUT_EN
    e.nm   = "timeout";
    e.data = 0;
    e.err  = 1;
    e.due  = cyc + 1 + 9;
    issue_raw(0, 0, 0, 32'h40, 32'h0, 0, 0, 1'b1, e);
    wait_done(50);
    chk("timeout_mem_valid", mem_valid_o, 0);
`else
    e.nm = "none";
    issue_raw(0, 0, 0, 32'h40, 32'h0, 0, 0, 1'b0, e);
    ready_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready_o) ready_seen = 1;
    end
    chk("stall_ready_low", ready_seen, 0);
    chk("stall_mem_valid", mem_valid_o, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    hang = 0;
    exp_issue = 0;
    issue(0, 0, 0, 32'h10, 32'h0, 1, 1, "ld_final");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
